env_adsr: RTL
=============

# env_adsr

ADSR envelope generator that consumes the single-cycle rising-edge pulses from the trigger edge detector: a note-on pulse starts or restarts the envelope and a note-off pulse starts release. The level advances only on a sample-rate strobe. The output feeds the voice amplitude multiplier. All outputs are registered.

## Interface
- ENV_W, 16: envelope level width; full scale is MAX = 2^ENV_W-1.
- RATE_W, 16: width of the per-sample step inputs; must be ≤ ENV_W.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- sample_en  in  1  one-cycle strobe at the audio sample rate; the level changes only on a cycle where it is high.
- trig  in  1  note-on pulse, one cycle wide, from the edge detector.
- rel  in  1  note-off pulse, one cycle wide.
- attack_rate  in  RATE_W  added per sample in ATTACK; 0 means instantaneous.
- decay_rate  in  RATE_W  subtracted per sample in DECAY; 0 means instantaneous.
- sustain_level  in  ENV_W  sustain target; sampled live.
- release_rate  in  RATE_W  subtracted per sample in RELEASE; 0 means instantaneous.
- env_level  out  ENV_W  current envelope level.
- env_state  out  3  current state (encoding in package).
- env_active  out  1  high when the state is not IDLE.
- env_done  out  1  one-cycle pulse when RELEASE reaches 0.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Events are checked every clk cycle, independent of sample_en. Priority: rst > trig > rel > level step.
- trig in any state: go to ATTACK. The level is not reset (soft retrigger from the current level). No level step occurs that cycle.
- rel in ATTACK, DECAY or SUSTAIN: go to RELEASE. No level step occurs that cycle. rel in IDLE or RELEASE is ignored.
- trig and rel in the same cycle: trig wins.
- Level steps occur only on sample_en with no event that cycle:
  - ATTACK: level = min(level+attack_rate, MAX). On reaching MAX, go to DECAY. If attack_rate=0, level = MAX immediately.
  - DECAY: if level−decay_rate ≤ sustain_level, underflows, or decay_rate=0, then level = sustain_level and go to SUSTAIN. Otherwise subtract decay_rate.
  - SUSTAIN: level = sustain_level on every sample_en. A changed sustain_level is tracked on the next strobe.
  - RELEASE: if level ≤ release_rate or release_rate=0, then level = 0, go to IDLE and pulse env_done. Otherwise subtract release_rate.
  - IDLE: level holds at 0.
- Arithmetic is done at ENV_W+1 bits. Rates are zero-extended. Results saturate; there is no wrap-around in either direction.
- sustain_level = MAX: DECAY exits to SUSTAIN on its first strobe with the level at MAX.

## Timing
- Reset values: env_level=0, env_state=IDLE, env_active=0, env_done=0.
- An event on cycle n is visible on env_state and env_active at n+1.
- A level step on a sample_en cycle n is visible on env_level at n+1. A state change caused by that step is also visible at n+1.
- env_done is high for exactly the one cycle in which env_state first reads IDLE after RELEASE.
- rst asserted mid-envelope forces the reset values on the next edge. No env_done pulse is generated.
- No backpressure exists. Pulses arriving closer than one cycle apart are not possible.

## Structure
- Package synth_env_pkg holds:
  - the env_state_t enum (3-bit): IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4;
  - the default ENV_W and RATE_W localparams.
- Sub-module env_step: combinational saturating add/subtract with a bound. Inputs are level, rate, bound and a direction flag. Outputs are the next level and a reached-bound flag. It is instantiated once and muxed per state.
- The top level contains the FSM and the output registers.

## Test plan
All cases use ENV_W=16, with sample_en high every cycle unless noted.
- Reset: hold rst 3 cycles, then release it → env_level=0x0000, env_state=IDLE, env_active=0, env_done=0.
- Full cycle: attack_rate=0x4000, decay_rate=0x1000, sustain_level=0xC000, one trig pulse →
  - env_level goes 0x4000, 0x8000, 0xC000, 0xFFFF, and the state becomes DECAY;
  - then 0xEFFF, 0xDFFF, 0xCFFF, 0xC000, and the state becomes SUSTAIN;
  - the level then holds at 0xC000.
- Release: in SUSTAIN at 0xC000 with release_rate=0x8000, one rel pulse → level 0x4000, then 0x0000 with state IDLE; env_done is high for exactly 1 cycle.
- Retrigger and collision:
  - trig during RELEASE at level 0x4000 → ATTACK continues from 0x4000, then 0x8000;
  - trig and rel in the same cycle from IDLE → ATTACK.
- Instant rates and strobe gating:
  - attack_rate=0 → 0xFFFF on the first strobe;
  - sample_en low for 10 cycles in ATTACK → level unchanged.
- Mid-run reset: rst during DECAY → next cycle level=0, state IDLE, env_done=0.

Source files
------------

// File: rtl/synth_env_pkg.sv
// Shared types and default widths for the ADSR envelope generator.
package synth_env_pkg;

    localparam int ENV_W_DEF  = 16;
    localparam int RATE_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/env_step.sv
// Combinational saturating step toward a bound: adds (down=0) or subtracts (down=1)
// a zero-extended rate at ENV_W+1 bits and clamps to the bound, flagging arrival.
module env_step #(
    parameter int ENV_W  = 16,
    parameter int RATE_W = 16
) (
    input  logic [ENV_W-1:0]  level,
    input  logic [RATE_W-1:0] rate,
    input  logic [ENV_W-1:0]  bound,
    input  logic              down,
    output logic [ENV_W-1:0]  next_level,
    output logic              reached
);

    logic [ENV_W:0] rate_x;
    logic [ENV_W:0] sum;
    logic [ENV_W:0] diff;

    assign rate_x = {{(ENV_W + 1 - RATE_W){1'b0}}, rate};
    assign sum    = {1'b0, level} + rate_x;
    assign diff   = {1'b0, level} - rate_x;

    // A zero rate means "jump to the bound"; diff[ENV_W] set means the subtraction underflowed.
    always_comb begin
        next_level = bound;
        reached    = 1'b1;
        if (rate != '0) begin
            if (down) begin
                if (!diff[ENV_W] && (diff[ENV_W-1:0] > bound)) begin
                    next_level = diff[ENV_W-1:0];
                    reached    = 1'b0;
                end
            end else if (sum < {1'b0, bound}) begin
                next_level = sum[ENV_W-1:0];
                reached    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/env_adsr.sv
// ADSR envelope generator: note-on/note-off events switch state every cycle,
// the level advances only on sample_en strobes through a shared env_step unit.
module env_adsr
    import synth_env_pkg::*;
#(
    parameter int ENV_W  = ENV_W_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              trig,
    input  logic              rel,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [ENV_W-1:0]  sustain_level,
    input  logic [RATE_W-1:0] release_rate,
    output logic [ENV_W-1:0]  env_level,
    output env_state_t        env_state,
    output logic              env_active,
    output logic              env_done
);

    localparam logic [ENV_W-1:0] MAX = '1;

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] level_q, level_d;
    logic             done_q, done_d;
    logic             active_q;

    logic [RATE_W-1:0] step_rate;
    logic [ENV_W-1:0]  step_bound;
    logic              step_down;
    logic [ENV_W-1:0]  step_level;
    logic              step_reached;

    // Attack climbs to full scale, decay falls to sustain, release falls to zero.
    always_comb begin
        step_rate  = attack_rate;
        step_bound = MAX;
        step_down  = 1'b0;
        case (state_q)
            ST_DECAY: begin
                step_rate  = decay_rate;
                step_bound = sustain_level;
                step_down  = 1'b1;
            end
            ST_RELEASE: begin
                step_rate  = release_rate;
                step_bound = '0;
                step_down  = 1'b1;
            end
            default: ;
        endcase
    end

    env_step #(
        .ENV_W  (ENV_W),
        .RATE_W (RATE_W)
    ) u_step (
        .level      (level_q),
        .rate       (step_rate),
        .bound      (step_bound),
        .down       (step_down),
        .next_level (step_level),
        .reached    (step_reached)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;
        if (trig) begin
            state_d = ST_ATTACK;
        end else if (rel && (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else if (sample_en) begin
            case (state_q)
                ST_ATTACK: begin
                    level_d = step_level;
                    if (step_reached) state_d = ST_DECAY;
                end
                ST_DECAY: begin
                    level_d = step_level;
                    if (step_reached) state_d = ST_SUSTAIN;
                end
                ST_SUSTAIN: level_d = sustain_level;
                ST_RELEASE: begin
                    level_d = step_level;
                    if (step_reached) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: level_d = '0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            level_q  <= '0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            done_q   <= done_d;
            active_q <= (state_d != ST_IDLE);
        end
    end

    assign env_level  = level_q;
    assign env_state  = state_q;
    assign env_active = active_q;
    assign env_done   = done_q;

endmodule
